// File: rtl/frame_crc_checker.sv
// Frame receiver: CRC-8/16 residue and payload-length check per frame, saturating good/bad statistics.
// Latency: one holding stage; status pulse is high in the cycle after the edge following the in_eof transfer.
// Backpressure: in_ready is low only in the single report cycle; otherwise every offered byte is accepted.
module frame_crc_checker #(
  parameter int               CRC_W   = 8,
  parameter logic [CRC_W-1:0] POLY    = 'h07,
  parameter logic [CRC_W-1:0] INIT    = '0,
  parameter int               MIN_LEN = 1,
  parameter int               MAX_LEN = 1500,
  parameter int               CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             in_sof,
  input  logic             in_eof,
  output logic             in_ready,
  input  logic             clr_stats,
  output logic             frame_done,
  output logic             crc_valid,
  output logic             crc_error,
  output logic             len_error,
  output logic             frame_abort,
  output logic [15:0]      frame_len,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] bad_cnt
);

  localparam int          NB    = CRC_W / 8;
  localparam logic [16:0] NB_L  = 17'(NB);
  localparam logic [16:0] MIN_L = 17'(MIN_LEN);
  localparam logic [16:0] MAX_L = 17'(MAX_LEN);
  localparam int          CW1   = CNT_W + 1;

  typedef enum logic [1:0] {IDLE, RECV, REPORT} state_t;

  state_t           state_q, state_n;
  logic             p_vld, p_sof, p_eof;
  logic [7:0]       p_dat;
  logic [CRC_W-1:0] crc_q, crc_n;
  logic [16:0]      tot_q, tot_n, pay;
  logic [15:0]      len_n;
  logic             done_n, abort_n, crc_err_n, len_err_n;
  logic             take, consume;
  logic [1:0]       bad_inc;
  logic [CNT_W:0]   good_sum, bad_sum;

  // MSB-first byte update: byte aligned to the top of the register, then 8 shift/XOR steps.
  function automatic logic [CRC_W-1:0] crc_upd(input logic [CRC_W-1:0] c_in, input logic [7:0] b);
    logic [CRC_W-1:0] c;
    c = c_in ^ (CRC_W'(b) << (CRC_W - 8));
    for (int i = 0; i < 8; i++) c = c[CRC_W-1] ? ((c << 1) ^ POLY) : (c << 1);
    return c;
  endfunction

  // The holding register is drained every cycle except in REPORT, so it never overflows.
  assign take    = in_valid & in_ready;
  assign consume = p_vld & (state_q != REPORT);

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_n;
  end

  // Next-state, CRC/count update and end-of-frame evaluation of the held byte
  always_comb begin
    state_n = state_q;
    crc_n   = crc_q;
    tot_n   = tot_q;
    done_n  = 1'b0;
    abort_n = 1'b0;
    case (state_q)
      IDLE: begin
        if (consume && p_sof) begin
          crc_n   = crc_upd(INIT, p_dat);
          tot_n   = 17'd1;
          done_n  = p_eof;
          state_n = p_eof ? REPORT : RECV;
        end
      end
      RECV: begin
        if (consume) begin
          if (p_sof) begin
            abort_n = 1'b1;
            crc_n   = crc_upd(INIT, p_dat);
            tot_n   = 17'd1;
          end else begin
            crc_n = crc_upd(crc_q, p_dat);
            tot_n = (tot_q == 17'h1FFFF) ? tot_q : tot_q + 17'd1;
          end
          if (p_eof) begin
            done_n  = 1'b1;
            state_n = REPORT;
          end
        end
      end
      REPORT:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
    pay       = (tot_n > NB_L) ? tot_n - NB_L : 17'd0;
    len_n     = (pay > 17'h0FFFF) ? 16'hFFFF : pay[15:0];
    crc_err_n = (crc_n != '0);
    len_err_n = (pay < MIN_L) || (pay > MAX_L);
  end

  // Input holding stage, accumulators and registered ready
  always_ff @(posedge clk) begin
    if (reset) begin
      p_vld    <= 1'b0;
      p_dat    <= '0;
      p_sof    <= 1'b0;
      p_eof    <= 1'b0;
      crc_q    <= INIT;
      tot_q    <= '0;
      in_ready <= 1'b0;
    end else begin
      p_vld <= take | (p_vld & ~consume);
      if (take) begin
        p_dat <= in_data;
        p_sof <= in_sof;
        p_eof <= in_eof;
      end
      crc_q    <= crc_n;
      tot_q    <= tot_n;
      in_ready <= (state_n != REPORT);
    end
  end

  // Registered per-frame status pulses; frame_len holds the last reported length
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_done  <= 1'b0;
      crc_valid   <= 1'b0;
      crc_error   <= 1'b0;
      len_error   <= 1'b0;
      frame_abort <= 1'b0;
      frame_len   <= '0;
    end else begin
      frame_done  <= done_n;
      crc_valid   <= done_n & ~crc_err_n & ~len_err_n;
      crc_error   <= done_n & crc_err_n;
      len_error   <= done_n & len_err_n;
      frame_abort <= abort_n;
      if (done_n) frame_len <= len_n;
    end
  end

  // An abort plus a failed report in the same cycle bumps bad_cnt by two.
  assign bad_inc  = {1'b0, frame_abort} + {1'b0, frame_done & ~crc_valid};
  assign good_sum = {1'b0, good_cnt} + CW1'(crc_valid);
  assign bad_sum  = {1'b0, bad_cnt} + CW1'(bad_inc);

  // Saturating statistics; a clear wins over a same-cycle increment
  always_ff @(posedge clk) begin
    if (reset || clr_stats) begin
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else begin
      good_cnt <= good_sum[CNT_W] ? '1 : good_sum[CNT_W-1:0];
      bad_cnt  <= bad_sum[CNT_W]  ? '1 : bad_sum[CNT_W-1:0];
    end
  end

endmodule
